// File: rtl/multicycle_divider.sv
// Iterative radix-2 restoring divider producing {remainder, quotient}, one quotient bit per cycle.
// Optional DIVIDER_EARLY_EXIT_EN skips the iteration loop when the quotient is trivially zero.
module multicycle_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               is_signed,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero,
    output logic [1:0]         state_dbg
);

    // Handshake: start is accepted only in IDLE outside the done-pulse cycle; no queuing.
    // done pulses for one cycle once result is valid; result holds until the next acceptance.
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sgn_q, neg_a_q, neg_b_q, dbz_q;

    logic               accept, skip, neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, q_fix, r_fix;
    logic [WIDTH:0]     trial;

    assign state_dbg = state_q;

    always_comb begin
        accept = (state_q == IDLE) && start && !done;
        neg_a  = is_signed & dividend[WIDTH-1];
        neg_b  = is_signed & divisor[WIDTH-1];
        // -(2^(WIDTH-1)) wraps to itself, which is the correct unsigned magnitude
        mag_a  = neg_a ? -dividend : dividend;
        mag_b  = neg_b ? -divisor  : divisor;
`ifdef DIVIDER_EARLY_EXIT_EN
        skip   = (divisor == '0) || (mag_a < mag_b);
`else
        skip   = 1'b0;
`endif
        trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        q_fix  = dbz_q ? '1 : ((sgn_q & (neg_a_q ^ neg_b_q)) ? -quo_q : quo_q);
        r_fix  = (sgn_q & neg_a_q) ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = skip ? FIX : RUN;
            RUN:  if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sgn_q       <= 1'b0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sgn_q   <= is_signed;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        dbz_q   <= (divisor == '0);
                        dvs_q   <= mag_b;
                        // quo_q doubles as the dividend shift register during RUN
                        quo_q   <= skip ? '0 : mag_a;
                        rem_q   <= skip ? mag_a : '0;
                        cnt_q   <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem_q <= trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    result      <= {r_fix, q_fix};
                    div_by_zero <= dbz_q;
                end
                default: ;
            endcase
        end
    end

endmodule
